// File: rtl/fp_accum_seq.sv
// Packet sum sequencer for the FP64 adder: feeds (running_sum, sample) pairs one at a time.
// FP_ACC_SKIP_ZERO_EN: when defined, +/-0.0 samples skip the adder and only bump the count.
module fp_accum_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [63:0]      add_a,
  output logic [63:0]      add_b,
  output logic             add_start,
  input  logic [63:0]      add_c,
  input  logic             add_done,
  output logic [63:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {S_ACCEPT, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  state_t           r_state, w_state;
  logic [63:0]      r_acc, w_acc;
  logic [63:0]      r_b, w_b;
  logic             r_last, w_last;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Saturating count: a very long packet reports all-ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state = r_state;
    w_acc   = r_acc;
    w_b     = r_b;
    w_last  = r_last;
    w_cnt   = r_cnt;
    case (r_state)
      S_ACCEPT: begin
        if (in_valid) begin
          w_cnt = w_cnt_inc;
`ifdef FP_ACC_SKIP_ZERO_EN
          if (in_data[62:0] == 63'd0) begin
            w_state = in_last ? S_OUTPUT : S_ACCEPT;
          end else begin
            w_b     = in_data;
            w_last  = in_last;
            w_state = S_ISSUE;
          end
`else
          w_b     = in_data;
          w_last  = in_last;
          w_state = S_ISSUE;
`endif
        end
      end
      S_ISSUE: w_state = S_WAIT;
      S_WAIT: begin
        if (add_done) begin
          w_acc   = add_c;
          w_state = r_last ? S_OUTPUT : S_ACCEPT;
        end
      end
      S_OUTPUT: begin
        // Clear to +0.0 so the next packet never inherits this sum.
        if (out_ready) begin
          w_acc   = 64'h0;
          w_cnt   = '0;
          w_state = S_ACCEPT;
        end
      end
      default: w_state = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCEPT;
      r_acc   <= 64'h0;
      r_b     <= 64'h0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_acc   <= w_acc;
      r_b     <= w_b;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
    end
  end

  assign in_ready  = (r_state == S_ACCEPT);
  assign add_start = (r_state == S_ISSUE);
  assign out_valid = (r_state == S_OUTPUT);
  assign add_a     = r_acc;
  assign add_b     = r_b;
  assign out_sum   = r_acc;
  assign out_count = r_cnt;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a 4-cycle behavioural FP64 adder and a result scoreboard.
module tb_fp_accum_seq;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [63:0]   add_a, add_b, add_c;
  logic          add_start, add_done;
  logic [63:0]   out_sum;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  logic [63:0]   q_sum[$];
  logic [CW-1:0] q_cnt[$];

  fp_accum_seq #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_c(add_c), .add_done(add_done), .out_sum(out_sum), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference adder: any NaN operand yields the canonical FFF8 NaN.
  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
    if ((a[62:52] == 11'h7FF && a[51:0] != 0) || (b[62:52] == 11'h7FF && b[51:0] != 0))
      return 64'hFFF8000000000000;
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  logic [3:0] st_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_pipe  <= '0;
      add_done <= 1'b0;
      add_c    <= '0;
    end else begin
      st_pipe  <= {st_pipe[2:0], add_start};
      add_done <= st_pipe[2];
      if (add_start) begin
        add_c   <= fadd(add_a, add_b);
        n_start <= n_start + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q_sum.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_out: got sum %h, no result expected", out_sum);
      end else begin
        chk("out_sum", out_sum, q_sum.pop_front());
        chk("out_count", 64'(out_count), 64'(q_cnt.pop_front()));
      end
    end
  end

  task automatic expect_result(input logic [63:0] s, input logic [CW-1:0] c);
    q_sum.push_back(s);
    q_cnt.push_back(c);
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    int t = 0;
    @(posedge clk); #1;
    in_data = d; in_last = last; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $error("FAIL send_timeout: in_ready stuck at 0 for sample %h", d);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q_sum.size() != 0 && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (q_sum.size() != 0) begin
      checks++; errors++;
      $error("FAIL drain_timeout: %0d results still pending", q_sum.size());
      q_sum.delete(); q_cnt.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_add_start", 64'(add_start), 64'd0);
    chk("rst_add_a", add_a, 64'h0);
    chk("rst_add_b", add_b, 64'h0);
    chk("rst_out_sum", out_sum, 64'h0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;

    // Three-sample packet
    expect_result(64'h400C000000000000, 2'd3);
    send(64'h3FF0000000000000, 1'b0);
    send(64'h4000000000000000, 1'b0);
    send(64'h3FE0000000000000, 1'b1);
    wait_drain();

    // Single negative sample: exactly one adder request
    n_start = 0;
    expect_result(64'hBFF8000000000000, 2'd1);
    send(64'hBFF8000000000000, 1'b1);
    wait_drain();
    chk("single_starts", 64'(n_start), 64'd1);

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    expect_result(64'h4000000000000000, 2'd1);
    send(64'h4000000000000000, 1'b1);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_sum", out_sum, 64'h4000000000000000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain();
    expect_result(64'h3FF0000000000000, 2'd1);
    send(64'h3FF0000000000000, 1'b1);
    wait_drain();

    // NaN propagation
    expect_result(64'hFFF8000000000000, 2'd2);
    send(64'h3FF0000000000000, 1'b0);
    send(64'h7FF8000000000000, 1'b1);
    wait_drain();

    // -0.0 alone sums to +0.0
    expect_result(64'h0000000000000000, 2'd1);
    send(64'h8000000000000000, 1'b1);
    wait_drain();

    // Counter saturates at all-ones (5 samples, 2-bit counter)
    expect_result(64'h4014000000000000, 2'd3);
    for (int i = 0; i < 5; i++) send(64'h3FF0000000000000, i == 4);
    wait_drain();

    // Zero samples: bypass the adder only when the skip feature is built in
    n_start = 0;
    expect_result(64'h3FF0000000000000, 2'd3);
    send(64'h0000000000000000, 1'b0);
    send(64'h8000000000000000, 1'b0);
    send(64'h3FF0000000000000, 1'b1);
    wait_drain();
`ifdef FP_ACC_SKIP_ZERO_EN
    chk("zero_starts", 64'(n_start), 64'd1);
`else
    chk("zero_starts", 64'(n_start), 64'd3);
`endif

    // Reset while the second sample is in the adder
    send(64'h3FF0000000000000, 1'b0);
    send(64'h4000000000000000, 1'b0);
    @(posedge clk); #1;
    chk("mid_add_a", add_a, 64'h3FF0000000000000);
    chk("mid_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_add_start", 64'(add_start), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_acc", add_a, 64'h0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_count", 64'(out_count), 64'd0);

    // Fresh packet after reset sees no stale sum
    expect_result(64'h4000000000000000, 2'd1);
    send(64'h4000000000000000, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
